// File: rtl/bram_port_arbiter.sv
// Shares one single-port 8-bit bram between r0 (CPU) and r1 (loader), sequencing big-endian
// byte/word accesses. Define ARB_FIXED_PRIO_EN to make r0 win every simultaneous request.
module bram_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    r0_req,
  input  logic                    r0_we,
  input  logic                    r0_word,
  input  logic [ADDR_W-1:0]       r0_addr,
  input  logic [8*WORD_BYTES-1:0] r0_wdata,
  output logic                    r0_ack,
  output logic [8*WORD_BYTES-1:0] r0_rdata,
  input  logic                    r1_req,
  input  logic                    r1_we,
  input  logic                    r1_word,
  input  logic [ADDR_W-1:0]       r1_addr,
  input  logic [8*WORD_BYTES-1:0] r1_wdata,
  output logic                    r1_ack,
  output logic [8*WORD_BYTES-1:0] r1_rdata,
  output logic                    busy,
  output logic                    mem_wea,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_dina,
  input  logic [7:0]              mem_douta
);
  localparam int DW = 8*WORD_BYTES;
  localparam int IW = $clog2(WORD_BYTES+1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
  typedef struct packed {
    logic              we;
    logic              word;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     wdata;
  } req_t;

  req_t [1:0]         cmd;
  logic [1:0]         req;
  state_t             state, state_nx;
  logic               gnt, gnt_nx, last_gnt;
  logic [IW-1:0]      idx, last_idx;
  logic [ADDR_W-1:0]  base, addr_q, cur_addr;
  logic [DW-1:0]      wd_sh, rd_word;
  logic [DW-9:0]      rd_sh;
  logic [1:0][DW-1:0] rdata_q;
  logic               rd_addr_phase, rd_last;

  assign req    = {r1_req, r0_req};
  assign cmd[0] = {r0_we, r0_word, r0_addr, r0_wdata};
  assign cmd[1] = {r1_we, r1_word, r1_addr, r1_wdata};

  assign cur_addr      = base + ADDR_W'(idx);
  assign rd_addr_phase = (idx <= last_idx);
  // douta lags the address by one cycle, so the last byte lands one cycle after the last address
  assign rd_last       = (idx == last_idx + IW'(1));
  assign rd_word       = {rd_sh, mem_douta};

  always_comb begin
    case (req)
      2'b10:   gnt_nx = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      2'b11:   gnt_nx = 1'b0;
`else
      2'b11:   gnt_nx = ~last_gnt;
`endif
      default: gnt_nx = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = cmd[gnt_nx].we ? WR : RD;
      WR:      if (idx == last_idx) state_nx = DONE;
      RD:      if (rd_last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      idx      <= '0;
      last_idx <= '0;
      base     <= '0;
      addr_q   <= '0;
      wd_sh    <= '0;
      rd_sh    <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          gnt      <= gnt_nx;
          base     <= cmd[gnt_nx].addr;
          last_idx <= cmd[gnt_nx].word ? IW'(WORD_BYTES-1) : '0;
          idx      <= '0;
          // byte writes are parked in the top lane so both sizes shift out MSB-first
          wd_sh    <= cmd[gnt_nx].word ? cmd[gnt_nx].wdata
                                       : {cmd[gnt_nx].wdata[7:0], {(DW-8){1'b0}}};
          rd_sh    <= '0;
        end
        WR: begin
          addr_q <= cur_addr;
          idx    <= idx + IW'(1);
          wd_sh  <= wd_sh << 8;
        end
        RD: begin
          if (rd_addr_phase) addr_q <= cur_addr;
          if (idx != '0)     rd_sh  <= rd_word[DW-9:0];
          if (rd_last)       rdata_q[gnt] <= rd_word;
          idx <= idx + IW'(1);
        end
        DONE:    last_gnt <= gnt;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_wea  = (state == WR);
    mem_addr = addr_q;
    if (state == WR || (state == RD && rd_addr_phase)) mem_addr = cur_addr;
    mem_dina = wd_sh[DW-1 -: 8];
    busy     = (state != IDLE);
    r0_ack   = (state == DONE) && !gnt;
    r1_ack   = (state == DONE) && gnt;
    r0_rdata = rdata_q[0];
    r1_rdata = rdata_q[1];
  end
endmodule
